vga_rect_fill: RTL
==================

// Module: vga_rect_fill
// PURPOSE
//  Frame-buffer writer. Takes rectangle-fill commands over a valid/ready handshake.
//  Emits one pixel write per cycle (we/addr_x/addr_y/color) in raster order.
//  Drives the write port of the VGA top-level video buffer; the VGA timing path reads that buffer.
// PARAMETERS
//  HD       800  visible columns; x range 0..HD-1
//  VD       600  visible rows; y range 0..VD-1
//  COORD_W  11   width of every coordinate/size field
// PORTS
//  clk_i        in   1        single clock
//  rst_i        in   1        reset, synchronous, active-high
//  cmd_valid_i  in   1        command present
//  cmd_ready_o  out  1        block can accept a command
//  cmd_x_i      in   COORD_W  left column x0
//  cmd_y_i      in   COORD_W  top row y0
//  cmd_w_i      in   COORD_W  width in pixels (0 allowed)
//  cmd_h_i      in   COORD_W  height in pixels (0 allowed)
//  cmd_color_i  in   2        vga_color_e code
//  abort_i      in   1        cancel current fill
//  we_o         out  1        pixel write strobe
//  addr_x_o     out  COORD_W  write column
//  addr_y_o     out  COORD_W  write row
//  color_o      out  2        write colour
//  busy_o       out  1        state != IDLE
//  done_o       out  1        one-cycle pulse at end of a command (completed or aborted)
// BEHAVIOUR
//  FSM: IDLE -> FILL -> DONE -> IDLE. Zero-area command: IDLE -> DONE directly.
//   abort_i in FILL: FILL -> DONE.
//  Reset (rst_i=1 at a clock edge): state=IDLE; we_o=0, addr_x_o=0, addr_y_o=0,
//   color_o=BLACK, done_o=0, busy_o=0. Any fill in progress is dropped; no further writes.
//  cmd_ready_o = (state==IDLE) && !abort_i && !rst_i.
//   Accept on cmd_valid_i && cmd_ready_o; x0/y0/w/h/color are latched at accept.
//  Timing, accept at edge T:
//   - first write (x0,y0) registered at T+1;
//   - one write per cycle, x increments first;
//   - when x = x0+w-1: x wraps to x0 and y increments;
//   - last write (x0+w-1, y0+h-1) at T+w*h;
//   - done_o at T+w*h+1;
//   - cmd_ready_o high again at T+w*h+2.
//  Zero-area command (w==0 or h==0, or fully clipped): no writes, done_o at T+1.
//  All outputs are registered. we_o is low in IDLE and DONE.
//   addr/color hold their last values while we_o=0.
//  abort_i high in FILL at edge E:
//   - no write at E+1;
//   - done_o pulses at E+1;
//   - back to IDLE at E+2.
//  Arithmetic: end coordinates x0+w and y0+h are computed in COORD_W+1 bits; no wrap.
//  abort_i in IDLE/DONE: ignored, except that it masks cmd_ready_o.
// CONFIGURATION
//  VGA_RECT_CLIP_EN defined:
//   - at accept, w_eff=min(w,HD-x0) and h_eff=min(h,VD-y0);
//   - x0>=HD or y0>=VD gives a zero-area command;
//   - every write lands inside HDxVD.
//  VGA_RECT_CLIP_EN undefined: no clipping. Writes go to exact coordinates,
//   including out-of-range ones; range checking is the caller's responsibility.
// STRUCTURE
//  vga_pkg: typedef enum logic [1:0] {BLACK,WHITE,BLUE,GREEN} vga_color_e;
//   typedef enum logic [1:0] {FILL_IDLE,FILL_RUN,FILL_DONE} vga_fill_state_e;
//   VGA_COORD_W constant.
//  Sub-module vga_raster_cnt: 2-D x/y counter.
//   Inputs: load, start, extent, step. Outputs: x, y, last.
//   The FSM wraps it and owns the output registers.
// TESTING
//  1. Reset mid-fill: rst_i high for 1 cycle during an (0,0,10,10) fill
//     -> we_o=0 the next cycle; no done_o; cmd_ready_o=1 the cycle after rst_i falls.
//  2. Cmd (10,20,3,2,BLUE) accepted at T
//     -> writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) at T+1..T+6,
//        color=BLUE; done_o at T+7; cmd_ready_o=1 at T+8.
//  3. Cmd w=0,h=5 -> no we_o; done_o at T+1.
//  4. Cmd (0,0,100,100) with abort_i pulsed at T+5
//     -> exactly 5 writes ((0,0)..(4,0)); done_o at T+6.
//  5. cmd_valid_i and abort_i both high in IDLE -> not accepted;
//     accepted the next cycle after abort_i drops.
//  6. VGA_RECT_CLIP_EN: cmd (798,599,5,3,WHITE) -> exactly 2 writes, (798,599),(799,599).
//     Without the macro: 15 writes, x up to 802, y up to 601.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA rectangle-fill writer.
// Colour codes, fill FSM states and coordinate width.
package vga_pkg;

   localparam int VGA_COORD_W = 11;

   typedef enum logic [1:0] {BLACK, WHITE, BLUE, GREEN} vga_color_e;

   typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} vga_fill_state_e;

endpackage

// File: rtl/vga_raster_cnt.sv
// Raster-order x/y walker over a rectangle, x advancing first.
// Counters are one bit wider than a coordinate so end positions never wrap.
module vga_raster_cnt #(
   parameter int W = 11
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [W-1:0] start_x_i,
   input  logic [W-1:0] start_y_i,
   input  logic [W-1:0] ext_x_i,
   input  logic [W-1:0] ext_y_i,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o,
   output logic         last_o
);

   logic [W:0] x_q, y_q, x0_q, xe_q, ye_q;
   logic       x_end;

   assign x_end  = (x_q + 1'b1) == xe_q;
   assign last_o = x_end && ((y_q + 1'b1) == ye_q);
   assign x_o    = x_q[W-1:0];
   assign y_o    = y_q[W-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q  <= '0;
         y_q  <= '0;
         x0_q <= '0;
         xe_q <= '0;
         ye_q <= '0;
      end else if (load_i) begin
         x_q  <= {1'b0, start_x_i};
         y_q  <= {1'b0, start_y_i};
         x0_q <= {1'b0, start_x_i};
         xe_q <= {1'b0, start_x_i} + {1'b0, ext_x_i};
         ye_q <= {1'b0, start_y_i} + {1'b0, ext_y_i};
      end else if (step_i) begin
         if (x_end) begin
            x_q <= x0_q;
            y_q <= y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill frame-buffer writer: one registered pixel write per cycle.
// Optional VGA_RECT_CLIP_EN clips each rectangle to the HD x VD screen.
module vga_rect_fill
   import vga_pkg::*;
#(
   parameter int HD      = 800,
   parameter int VD      = 600,
   parameter int COORD_W = VGA_COORD_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [COORD_W-1:0] cmd_x_i,
   input  logic [COORD_W-1:0] cmd_y_i,
   input  logic [COORD_W-1:0] cmd_w_i,
   input  logic [COORD_W-1:0] cmd_h_i,
   input  logic [1:0]         cmd_color_i,
   input  logic               abort_i,
   output logic               we_o,
   output logic [COORD_W-1:0] addr_x_o,
   output logic [COORD_W-1:0] addr_y_o,
   output logic [1:0]         color_o,
   output logic               busy_o,
   output logic               done_o
);

   vga_fill_state_e    state_q, state_d;
   vga_color_e         fcol_q, col_q, col_d;
   logic               accept, zero_area, cnt_last;
   logic [COORD_W-1:0] w_eff, h_eff, cnt_x, cnt_y;
   logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d;
   logic               we_q, we_d, done_q, done_d;

   assign cmd_ready_o = (state_q == FILL_IDLE) && !abort_i && !rst_i;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign zero_area   = (w_eff == '0) || (h_eff == '0);

   always_comb begin
      w_eff = cmd_w_i;
      h_eff = cmd_h_i;
`ifdef VGA_RECT_CLIP_EN
      if (cmd_x_i >= COORD_W'(HD))
         w_eff = '0;
      else if (cmd_w_i > COORD_W'(HD) - cmd_x_i)
         w_eff = COORD_W'(HD) - cmd_x_i;
      if (cmd_y_i >= COORD_W'(VD))
         h_eff = '0;
      else if (cmd_h_i > COORD_W'(VD) - cmd_y_i)
         h_eff = COORD_W'(VD) - cmd_y_i;
`endif
   end

   vga_raster_cnt #(.W(COORD_W)) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (accept),
      .step_i   (state_q == FILL_RUN),
      .start_x_i(cmd_x_i),
      .start_y_i(cmd_y_i),
      .ext_x_i  (w_eff),
      .ext_y_i  (h_eff),
      .x_o      (cnt_x),
      .y_o      (cnt_y),
      .last_o   (cnt_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FILL_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL_IDLE: if (accept) state_d = zero_area ? FILL_DONE : FILL_RUN;
         FILL_RUN:  if (abort_i || cnt_last) state_d = FILL_DONE;
         FILL_DONE: state_d = FILL_IDLE;
         default:   state_d = FILL_IDLE;
      endcase
   end

   // The write issued on the abort edge still lands; only later ones are dropped.
   always_comb begin
      we_d   = 1'b0;
      done_d = 1'b0;
      ax_d   = ax_q;
      ay_d   = ay_q;
      col_d  = col_q;
      unique case (state_q)
         FILL_RUN: begin
            we_d  = 1'b1;
            ax_d  = cnt_x;
            ay_d  = cnt_y;
            col_d = fcol_q;
         end
         FILL_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fcol_q <= BLACK;
         col_q  <= BLACK;
         we_q   <= 1'b0;
         done_q <= 1'b0;
         ax_q   <= '0;
         ay_q   <= '0;
      end else begin
         if (accept) fcol_q <= vga_color_e'(cmd_color_i);
         col_q  <= col_d;
         we_q   <= we_d;
         done_q <= done_d;
         ax_q   <= ax_d;
         ay_q   <= ay_d;
      end
   end

   assign we_o     = we_q;
   assign done_o   = done_q;
   assign addr_x_o = ax_q;
   assign addr_y_o = ay_q;
   assign color_o  = col_q;
   assign busy_o   = state_q != FILL_IDLE;

endmodule
